// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_det_pkg;

   localparam logic MODE_NONOVL = 1'b0;
   localparam logic MODE_OVL    = 1'b1;

   // A length of zero, or one longer than the history, means "use the full history".
   function automatic int unsigned clamp_len(input int unsigned pat_len,
                                             input int unsigned pat_w);
      if ((pat_len == 0) || (pat_len > pat_w)) begin
         return pat_w;
      end
      return pat_len;
   endfunction

endpackage

// File: rtl/seq_det_history.sv
// Serial history shift register with a saturating count of valid bits.
// Latency: state updates on the edge after shift_en; *_next expose the post-shift view combinationally.
// Backpressure: none; shifts whenever shift_en is high, clr wins over shift_en.
module seq_det_history #(
   parameter int PAT_W = 8,
   parameter int LEN_W = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             shift_en,
   input  logic             din,
   input  logic             clr,
   output logic [PAT_W-1:0] hist_next,
   output logic [LEN_W-1:0] fill,
   output logic [LEN_W-1:0] fill_next
);

   logic [PAT_W-1:0] hist;

   // Post-shift view, used by the parent to decide a match in the same cycle the bit arrives.
   always_comb begin
      hist_next = {hist[PAT_W-2:0], din};
      fill_next = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
   end

   // History and fill registers; a clear discards any bit shifted in the same cycle.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         hist <= '0;
         fill <= '0;
      end else if (shift_en) begin
         hist <= hist_next;
         fill <= fill_next;
      end
   end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector: 1..PAT_W bit pattern, overlapping or non-overlapping, saturating match count.
// Latency: out pulses one cycle after the accepted bit that completes the pattern; match_count updates on that edge.
// Backpressure: none; bits are taken whenever in_valid is high, cfg_load discards a coincident bit.
module seq_detector_prog
   import seq_det_pkg::*;
#(
   parameter int PAT_W = 8,
   parameter int CNT_W = 16,
   parameter int LEN_W = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] pat_len,
   input  logic             overlap,
   input  logic             in_valid,
   input  logic             in,
   output logic             out,
   output logic [CNT_W-1:0] match_count,
   output logic [LEN_W-1:0] fill
);

   logic [PAT_W-1:0] pat_q;
   logic [LEN_W-1:0] len_q;
   logic             ovl_q;

   logic [PAT_W-1:0] hist_next;
   logic [LEN_W-1:0] fill_next;
   logic [PAT_W-1:0] mask;
   logic             accept;
   logic             hit;
   logic             hist_clr;

   // Latched configuration; a new config applies from the next accepted bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         pat_q <= '0;
         len_q <= LEN_W'(PAT_W);
         ovl_q <= MODE_NONOVL;
      end else if (cfg_load) begin
         pat_q <= pattern;
         len_q <= LEN_W'(clamp_len(32'(pat_len), PAT_W));
         ovl_q <= overlap;
      end
   end

   // Match decision against the window that includes the bit arriving this cycle.
   always_comb begin
      accept   = in_valid && !cfg_load;
      // Low len_q bits set; a shift by the full width yields zero, so len_q == PAT_W gives all ones.
      mask     = ~({PAT_W{1'b1}} << len_q);
      hit      = accept && (fill_next >= len_q) && (((hist_next ^ pat_q) & mask) == '0);
      // Non-overlap restarts the window so no matched bit is reused.
      hist_clr = cfg_load || (hit && (ovl_q != MODE_OVL));
   end

   seq_det_history #(
      .PAT_W (PAT_W),
      .LEN_W (LEN_W)
   ) u_history (
      .clk       (clk),
      .reset     (reset),
      .shift_en  (accept),
      .din       (in),
      .clr       (hist_clr),
      .hist_next (hist_next),
      .fill      (fill),
      .fill_next (fill_next)
   );

   // Registered one-cycle match pulse.
   always_ff @(posedge clk) begin
      if (reset || cfg_load) begin
         out <= 1'b0;
      end else begin
         out <= hit;
      end
   end

   // Match counter, holding at all-ones.
   always_ff @(posedge clk) begin
      if (reset || cfg_load) begin
         match_count <= '0;
      end else if (hit && (match_count != '1)) begin
         match_count <= match_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog: two instances (16-bit and 2-bit counters) fed the same stream.
// Latency: a queue-based model predicts out/match_count/fill, compared on every falling edge.
// Backpressure: n/a.
module tb_seq_detector_prog;

   localparam int PAT_W = 8;
   localparam int LEN_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             cfg_load;
   logic [PAT_W-1:0] pattern;
   logic [LEN_W-1:0] pat_len;
   logic             overlap;
   logic             in_valid;
   logic             din;

   logic             out_a, out_b;
   logic [15:0]      cnt_a;
   logic [1:0]       cnt_b;
   logic [LEN_W-1:0] fill_a, fill_b;

   int errors = 0;
   int checks = 0;
   int pulses_a = 0;
   int pulses_b = 0;
   bit chk_en = 1'b0;

   // Model state: accepted bits of the current window, oldest first.
   bit         mq[$];
   int         m_len;
   logic [7:0] m_pat;
   bit         m_ovl;
   bit         m_out;
   int         m_cnt_a;
   int         m_cnt_b;

   always #5 clk = ~clk;

   seq_detector_prog #(.PAT_W(PAT_W), .CNT_W(16)) u_dut_a (
      .clk(clk), .reset(reset), .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
      .overlap(overlap), .in_valid(in_valid), .in(din), .out(out_a), .match_count(cnt_a),
      .fill(fill_a)
   );

   seq_detector_prog #(.PAT_W(PAT_W), .CNT_W(2)) u_dut_b (
      .clk(clk), .reset(reset), .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
      .overlap(overlap), .in_valid(in_valid), .in(din), .out(out_b), .match_count(cnt_b),
      .fill(fill_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model of one clock edge, written from the detection rules.
   task automatic model_step(input bit r, input bit c, input bit v, input bit b);
      bit hit;
      if (r) begin
         mq.delete();
         m_len = PAT_W; m_pat = '0; m_ovl = 1'b0;
         m_out = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
      end else if (c) begin
         m_len = ((pat_len == 0) || (int'(pat_len) > PAT_W)) ? PAT_W : int'(pat_len);
         m_pat = pattern; m_ovl = overlap;
         mq.delete();
         m_out = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
      end else if (v) begin
         mq.push_back(b);
         if (mq.size() > PAT_W) void'(mq.pop_front());
         hit = (mq.size() >= m_len);
         for (int i = 0; i < m_len; i++) begin
            if (hit && (mq[mq.size() - 1 - i] != m_pat[i])) hit = 1'b0;
         end
         m_out = hit;
         if (hit) begin
            if (m_cnt_a < 65535) m_cnt_a++;
            if (m_cnt_b < 3) m_cnt_b++;
            if (!m_ovl) mq.delete();
         end
      end else begin
         m_out = 1'b0;
      end
   endtask

   task automatic cyc(input bit r, input bit c, input bit v, input bit b);
      @(negedge clk);
      reset = r; cfg_load = c; in_valid = v; din = b;
      @(posedge clk);
      #1;
      model_step(r, c, v, b);
   endtask

   task automatic send(input bit b);
      cyc(1'b0, 1'b0, 1'b1, b);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
      pattern = p; pat_len = l; overlap = o;
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("out_a", 32'(out_a), 32'(m_out));
         check("out_b", 32'(out_b), 32'(m_out));
         check("count_a", 32'(cnt_a), 32'(m_cnt_a));
         check("count_b", 32'(cnt_b), 32'(m_cnt_b));
         check("fill_a", 32'(fill_a), 32'(mq.size()));
         check("fill_b", 32'(fill_b), 32'(mq.size()));
      end
   end

   // Pulse tallies taken from the DUT outputs.
   always @(negedge clk) begin
      if (chk_en) begin
         pulses_a <= pulses_a + int'(out_a);
         pulses_b <= pulses_b + int'(out_b);
      end
   end

   initial begin
      int p0;
      reset = 1'b1; cfg_load = 1'b0; in_valid = 1'b0; din = 1'b0;
      pattern = '0; pat_len = '0; overlap = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check("reset_out", 32'(out_a), 32'd0);
      check("reset_count", 32'(cnt_a), 32'd0);
      check("reset_fill", 32'(fill_a), 32'd0);
      chk_en = 1'b1;

      // Non-overlap 1010 over 10101010: pulses after bits 4 and 8.
      load(8'b1010, 4'd4, 1'b0);
      p0 = pulses_a;
      for (int i = 0; i < 8; i++) send(bit'((i % 2) == 0));
      idle();
      check("t1_count", 32'(cnt_a), 32'd2);
      check("t1_pulses", 32'(pulses_a - p0), 32'd2);
      check("t1_fill", 32'(fill_a), 32'd0);

      // Overlap, same stream: pulses after bits 4, 6, 8.
      load(8'b1010, 4'd4, 1'b1);
      p0 = pulses_a;
      for (int i = 0; i < 8; i++) send(bit'((i % 2) == 0));
      idle();
      check("t2_count", 32'(cnt_a), 32'd3);
      check("t2_pulses", 32'(pulses_a - p0), 32'd3);
      check("t2_fill", 32'(fill_a), 32'd8);

      // 111, len 3, overlap, five 1s separated by gaps.
      load(8'b111, 4'd3, 1'b1);
      p0 = pulses_a;
      for (int i = 0; i < 5; i++) begin
         send(1'b1);
         idle();
      end
      check("t3_count", 32'(cnt_a), 32'd3);
      check("t3_pulses", 32'(pulses_a - p0), 32'd3);
      check("t3_count_b", 32'(cnt_b), 32'd3);

      // pat_len 0 acts as full length: all-zero pattern needs eight bits.
      load(8'h00, 4'd0, 1'b0);
      for (int i = 0; i < 7; i++) send(1'b0);
      check("t4_len0_before", 32'(cnt_a), 32'd0);
      send(1'b0);
      check("t4_len0_after", 32'(cnt_a), 32'd1);

      // pat_len above PAT_W also clamps to full length.
      load(8'hFF, 4'd12, 1'b1);
      for (int i = 0; i < 7; i++) send(1'b1);
      check("t4_len12_before", 32'(cnt_a), 32'd0);
      send(1'b1);
      send(1'b1);
      check("t4_len12_after", 32'(cnt_a), 32'd2);

      // cfg_load together with the completing bit: bit discarded, state cleared.
      load(8'b1010, 4'd4, 1'b0);
      send(1'b1); send(1'b0); send(1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      check("t4_cfgwin_out", 32'(out_a), 32'd0);
      check("t4_cfgwin_count", 32'(cnt_a), 32'd0);
      check("t4_cfgwin_fill", 32'(fill_a), 32'd0);

      // Reset mid-pattern loses partial history and config.
      load(8'b1010, 4'd4, 1'b0);
      send(1'b1); send(1'b0); send(1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check("t5_reset_fill", 32'(fill_a), 32'd0);
      load(8'b1010, 4'd4, 1'b0);
      send(1'b0);
      check("t5_nomatch", 32'(cnt_a), 32'd0);
      p0 = pulses_a;
      send(1'b1); send(1'b0); send(1'b1); send(1'b0);
      idle();
      check("t5_count", 32'(cnt_a), 32'd1);
      check("t5_pulses", 32'(pulses_a - p0), 32'd1);

      // Single-bit pattern, overlap: 2-bit counter saturates, pulses continue.
      load(8'b1, 4'd1, 1'b1);
      p0 = pulses_b;
      for (int i = 0; i < 6; i++) send(1'b1);
      idle();
      check("t6_count_b", 32'(cnt_b), 32'd3);
      check("t6_count_a", 32'(cnt_a), 32'd6);
      check("t6_pulses_b", 32'(pulses_b - p0), 32'd6);

      idle();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
